w_b_i_bram_loader: RTL and testbench

Write-side loader for the W_B_I buffer BRAM. It accepts a stream of 32-bit words over a valid/ready handshake and drives BRAM Port A (`ena`/`wea`/`addra`/`dina`) to fill a programmed region, with an optional row stride. It pulses `load_done` when the region is complete, so the fetch logic on Port B can be started. It replaces testbench-driven Port A preloading with a synthesizable producer.

---
 rtl/w_b_i_pkg.sv | 9 +
 rtl/bram_load_addr_gen.sv | 40 ++++
 rtl/w_b_i_bram_loader.sv | 73 +++++++
 tb/tb_w_b_i_bram_loader.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/w_b_i_pkg.sv
// w_b_i_pkg: shared widths and FSM encoding for the W_B_I BRAM loader
package w_b_i_pkg;
  localparam int BRAM_ADDR_WIDTH = 14;
  localparam int WORD_WIDTH = 32;
  localparam int DATA_WIDTH = 256;
  localparam int ROW_WORDS = DATA_WIDTH / WORD_WIDTH;
  localparam int COUNT_WIDTH = 15;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/bram_load_addr_gen.sv
// bram_load_addr_gen: row/column Port A address generator with stride and wrap detect
module bram_load_addr_gen #(
  parameter int AW = 14,
  parameter int ROW_WORDS = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] base,
  input  logic [7:0]    stride,
  input  logic          advance,
  output logic [AW-1:0] addr,
  output logic          wrap
);
  localparam int CW = $clog2(ROW_WORDS);
  logic [AW-1:0] row_start;
  logic [CW-1:0] col;
  logic [7:0]    stride_q;
  logic [AW:0]   next_row;
  logic          row_end;
  assign row_end = col == CW'(ROW_WORDS - 1);
  assign next_row = {1'b0, row_start} + {1'b0, AW'(stride_q) << CW};
  // row_start stays aligned, so adding col can never carry
  assign addr = row_start + AW'(col);
  assign wrap = advance && row_end && next_row[AW];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_start <= '0;
      col <= '0;
      stride_q <= '0;
    end else if (load) begin
      row_start <= base & ~AW'(ROW_WORDS - 1);
      col <= '0;
      stride_q <= stride == 8'd0 ? 8'd1 : stride;
    end else if (advance) begin
      col <= row_end ? '0 : col + CW'(1);
      if (row_end) row_start <= next_row[AW-1:0];
    end
  end
endmodule

// File: rtl/w_b_i_bram_loader.sv
// w_b_i_bram_loader: stream-to-BRAM Port A loader with strided row placement
module w_b_i_bram_loader #(
  parameter int BRAM_ADDR_WIDTH = 14,
  parameter int WORD_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int COUNT_WIDTH = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_load,
  input  logic [BRAM_ADDR_WIDTH-1:0] base_addr,
  input  logic [COUNT_WIDTH-1:0]     word_count,
  input  logic [7:0]                 row_stride,
  input  logic                       abort,
  input  logic [WORD_WIDTH-1:0]      s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic                       ena,
  output logic                       wea,
  output logic [BRAM_ADDR_WIDTH-1:0] addra,
  output logic [WORD_WIDTH-1:0]      dina,
  output logic                       busy,
  output logic                       load_done,
  output logic                       addr_wrap
);
  import w_b_i_pkg::*;
  localparam int RW = DATA_WIDTH / WORD_WIDTH;
  state_t state, state_n;
  logic [COUNT_WIDTH-1:0]     total, cnt;
  logic [BRAM_ADDR_WIDTH-1:0] gen_addr;
  logic accept, last, start, wrap;
  assign s_ready = state == LOAD && !abort;
  assign accept = s_valid && s_ready;
  assign last = cnt + COUNT_WIDTH'(1) == total;
  assign start = state == IDLE && start_load;
  assign busy = state != IDLE;
  assign load_done = state == DONE;
  assign wea = ena;
  always_comb begin
    state_n = IDLE;
    if (state == IDLE) state_n = start_load ? (word_count == '0 ? DONE : LOAD) : IDLE;
    else if (state == LOAD) state_n = abort ? IDLE : (accept && last ? DONE : LOAD);
  end
  bram_load_addr_gen #(.AW(BRAM_ADDR_WIDTH), .ROW_WORDS(RW)) u_addr_gen (
    .clk(clk),
    .rst(rst),
    .load(start),
    .base(base_addr),
    .stride(row_stride),
    .advance(accept),
    .addr(gen_addr),
    .wrap(wrap)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      total <= '0;
      cnt <= '0;
      ena <= 1'b0;
      addra <= '0;
      dina <= '0;
      addr_wrap <= 1'b0;
    end else begin
      state <= state_n;
      ena <= accept;
      if (accept) addra <= gen_addr;
      if (accept) dina <= s_data;
      if (start) total <= word_count;
      cnt <= start ? '0 : (accept ? cnt + COUNT_WIDTH'(1) : cnt);
      addr_wrap <= start ? 1'b0 : (addr_wrap | wrap);
    end
  end
endmodule

// File: tb/tb_w_b_i_bram_loader.sv
// tb_w_b_i_bram_loader: randomized directed checks of the loader against an address/data model
module tb_w_b_i_bram_loader;
  logic        clk = 1'b0, rst = 1'b1, start_load = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic [13:0] base_addr = '0;
  logic [14:0] word_count = '0;
  logic [7:0]  row_stride = '0;
  logic [31:0] s_data = '0;
  logic        s_ready, ena, wea, busy, load_done, addr_wrap;
  logic [13:0] addra;
  logic [31:0] dina;
  int n_chk = 0, n_fail = 0, cyc = 0, ld_cnt = 0;
  logic [13:0] oa[$];
  logic [31:0] od[$];
  int          oc[$];

  w_b_i_bram_loader dut (
    .clk(clk), .rst(rst), .start_load(start_load), .base_addr(base_addr),
    .word_count(word_count), .row_stride(row_stride), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .ena(ena), .wea(wea),
    .addra(addra), .dina(dina), .busy(busy), .load_done(load_done), .addr_wrap(addr_wrap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (ena === 1'b1) begin
      oa.push_back(addra);
      od.push_back(dina);
      oc.push_back(cyc);
    end
    if (load_done === 1'b1) ld_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [13:0] b, input int c, input logic [7:0] s);
    @(posedge clk);
    #1;
    base_addr = b;
    word_count = 15'(c);
    row_stride = s;
    start_load = 1'b1;
    @(posedge clk);
    #1;
    start_load = 1'b0;
    base_addr = $urandom;
    word_count = 15'($urandom);
    row_stride = 8'($urandom);
  endtask

  // mode 0: valid always, 1: valid every third cycle, 2: random valid and noisy config inputs
  task automatic run_load(input logic [13:0] b, input int c, input logic [7:0] s, input int mode, input string tag);
    logic [13:0] ea[$];
    logic [31:0] dq[$];
    int idx, budget, se, alig, ld0;
    bit wexp;
    se = s == 8'd0 ? 1 : int'(s);
    alig = int'(b) & 'h3ff8;
    for (int k = 0; k < c; k++) begin
      ea.push_back(14'(alig + (k / 8) * se * 8 + k % 8));
      dq.push_back($urandom);
    end
    wexp = (alig + (c / 8) * se * 8) >= 16384;
    oa.delete();
    od.delete();
    oc.delete();
    ld0 = ld_cnt;
    start(b, c, s);
    chk({tag, " busy_after_start"}, busy, 1);
    chk({tag, " s_ready_after_start"}, s_ready, c != 0);
    chk({tag, " early_load_done"}, load_done, c == 0);
    idx = 0;
    budget = 0;
    while (idx < c && budget < 20 * c + 20) begin
      s_valid = mode == 0 ? 1'b1 : mode == 1 ? (budget % 3 == 0) : ($urandom_range(0, 2) != 0);
      s_data = dq[idx];
      if (mode == 2) begin
        start_load = 1'($urandom);
        word_count = 15'($urandom);
        base_addr = $urandom;
      end
      #1;
      chk({tag, " s_ready_in_load"}, s_ready, 1);
      if (s_valid) idx++;
      @(posedge clk);
      #1;
      budget++;
    end
    s_valid = 1'b0;
    start_load = 1'b0;
    chk({tag, " beats_accepted"}, idx, c);
    chk({tag, " load_done_pulse"}, load_done, 1);
    if (c != 0) begin
      chk({tag, " final_ena"}, ena, 1);
      chk({tag, " final_wea"}, wea, 1);
      chk({tag, " final_addr"}, addra, ea[c-1]);
    end
    @(posedge clk);
    #1;
    chk({tag, " load_done_cleared"}, load_done, 0);
    chk({tag, " busy_cleared"}, busy, 0);
    chk({tag, " s_ready_idle"}, s_ready, 0);
    chk({tag, " write_count"}, oa.size(), c);
    for (int k = 0; k < c && k < oa.size(); k++) begin
      chk({tag, " addr"}, oa[k], ea[k]);
      chk({tag, " data"}, od[k], dq[k]);
      if (mode == 0) chk({tag, " back_to_back"}, oc[k], oc[0] + k);
    end
    chk({tag, " addr_wrap"}, addr_wrap, wexp);
    chk({tag, " done_pulses"}, ld_cnt - ld0, 1);
  endtask

  initial begin
    #12;
    chk("rst s_ready", s_ready, 0);
    chk("rst ena", ena, 0);
    chk("rst wea", wea, 0);
    chk("rst addra", addra, 0);
    chk("rst dina", dina, 0);
    chk("rst busy", busy, 0);
    chk("rst load_done", load_done, 0);
    chk("rst addr_wrap", addr_wrap, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_load(14'h0100, 16, 8'd1, 0, "contig");
    run_load(14'h0000, 16, 8'd4, 0, "stride");
    run_load(14'h0040, 8, 8'd1, 1, "backpressure");
    run_load(14'h0123, 0, 8'd1, 0, "zero");
    run_load(14'h3ff8, 12, 8'd1, 0, "wrap");
    // abort after five beats of sixteen
    oa.delete();
    od.delete();
    begin
      int ld0;
      ld0 = ld_cnt;
      start(14'h0200, 16, 8'd1);
      s_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
        s_data = 32'(100 + i);
        @(posedge clk);
        #1;
      end
      abort = 1'b1;
      s_data = 32'd999;
      #1;
      chk("abort s_ready", s_ready, 0);
      chk("abort beat5_ena", ena, 1);
      chk("abort beat5_addr", addra, 14'h0204);
      chk("abort beat5_data", dina, 104);
      @(posedge clk);
      #1;
      abort = 1'b0;
      s_valid = 1'b0;
      chk("abort idle", busy, 0);
      chk("abort no_write", ena, 0);
      @(posedge clk);
      #1;
      chk("abort writes", oa.size(), 5);
      chk("abort no_done", ld_cnt - ld0, 0);
    end
    run_load(14'h0500, 10, 8'd2, 0, "after_abort");
    // asynchronous reset in the middle of a load
    start(14'h0300, 16, 8'd2);
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = $urandom;
      @(posedge clk);
      #1;
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst ena", ena, 0);
    chk("midrst addra", addra, 0);
    chk("midrst dina", dina, 0);
    chk("midrst busy", busy, 0);
    chk("midrst s_ready", s_ready, 0);
    chk("midrst load_done", load_done, 0);
    s_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    run_load(14'h0300, 16, 8'd2, 0, "after_rst");
    for (int r = 0; r < 6; r++)
      run_load(14'($urandom), $urandom_range(1, 40), r == 0 ? 8'd0 : 8'($urandom), 2, "random");
    run_load(14'h3f00, 24, 8'd16, 2, "random_wrap");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
